// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - time-multiplexed, double-buffered seven-segment scan controller
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN (suppresses leading zero digits when defined)
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [4*NUM_DIGITS-1:0]                             value,
    input  logic [NUM_DIGITS-1:0]                               dp_mask,
    input  logic [NUM_DIGITS-1:0]                               digit_en,
    input  logic                                                load,
    output logic [3:0]                                          nibble,
    output logic [NUM_DIGITS-1:0]                               an,
    output logic                                                dp_n,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                                frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    // r_run is clear only in the cycle straight out of reset; that idle cycle lets the
    // first post-reset edge present slot 0 / prescaler 0 with frame_start high.
    logic                    r_run;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;
    logic [4*NUM_DIGITS-1:0] r_act_val;
    logic [NUM_DIGITS-1:0]   r_act_dp;

    logic                    w_cnt_wrap;
    logic                    w_swap;
    logic [CW-1:0]           w_cnt_nxt;
    logic [IW-1:0]           w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_act_val_nxt;
    logic [NUM_DIGITS-1:0]   w_act_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_show;
    logic [3:0]              w_nib_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic                    w_dpn_nxt;
    logic                    w_fs_nxt;

    // Next prescaler/slot position and the active buffer that position will display.
    // Outputs are registered from these next-state values so they line up with the
    // prescaler and digit_idx registers in the same cycle.
    always_comb begin
        w_cnt_wrap    = (r_cnt == CNT_LAST);
        w_swap        = r_run && w_cnt_wrap && (r_idx == IDX_LAST) && r_pend_valid;
        w_cnt_nxt     = '0;
        w_idx_nxt     = '0;
        if (r_run) begin
            w_cnt_nxt = w_cnt_wrap ? '0 : r_cnt + 1'b1;
            w_idx_nxt = r_idx;
            if (w_cnt_wrap) begin
                w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
        w_act_val_nxt = w_swap ? r_pend_val : r_act_val;
        w_act_dp_nxt  = w_swap ? r_pend_dp  : r_act_dp;
        w_fs_nxt      = (w_cnt_nxt == '0) && (w_idx_nxt == '0);
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit is shown when it or any more-significant active nibble is non-zero; digit 0 always.
    always_comb begin
        w_show = '1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            w_show[i] = |(w_act_val_nxt >> (4 * i));
        end
    end
`else
    assign w_show = '1;
`endif

    // Select the scanned digit's nibble and drive at most one anode outside the blank interval.
    always_comb begin
        w_nib_nxt = '0;
        w_an_nxt  = '1;
        w_dpn_nxt = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_nib_nxt = w_act_val_nxt[4*i +: 4];
                if ((w_cnt_nxt >= BLANK_END) && digit_en[i] && w_show[i]) begin
                    w_an_nxt[i] = 1'b0;
                    w_dpn_nxt   = ~w_act_dp_nxt[i];
                end
            end
        end
    end

    // Prescaler, slot index and the pending/active double buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
        end else begin
            r_run <= 1'b1;
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
            if (w_swap) begin
                r_act_val <= r_pend_val;
                r_act_dp  <= r_pend_dp;
            end
            // A load on the frame boundary lands in pending after the old contents moved on.
            if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_mask;
                r_pend_valid <= 1'b1;
            end else if (w_swap) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            nibble      <= '0;
            an          <= '1;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            nibble      <= w_nib_nxt;
            an          <= w_an_nxt;
            dp_n        <= w_dpn_nxt;
            frame_start <= w_fs_nxt;
        end
    end

    assign digit_idx = r_idx;

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Cycles through NUM_DIGITS digit slots.
- For each slot, drives one 4-bit nibble to the shared SSD hex decoder and enables exactly one active-low anode.
- Double-buffers the displayed value so updates only take effect at frame boundaries, giving tear-free display.
- Sits between the core's debug/output register and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value  input  4*NUM_DIGITS  digit nibbles; digit i = value[4*i+3:4*i], digit 0 is rightmost
dp_mask  input  NUM_DIGITS  decimal point request per digit, active-high
digit_en  input  NUM_DIGITS  per-digit enable; disabled digits are never lit
load  input  1  one-cycle strobe capturing value/dp_mask into the pending buffer
nibble  output  4  current digit's nibble, fed to the SSD decoder
an  output  NUM_DIGITS  anode enables, active-low
dp_n  output  1  decimal point segment, active-low
digit_idx  output  clog2(NUM_DIGITS) (min 1)  index of the slot currently scanned
frame_start  output  1  one-cycle pulse on the first cycle of slot 0

Behaviour:
- All state is in one clock domain, and all updates happen on the rising edge of clk.
- Reset values:
  - an = all ones; dp_n = 1; nibble = 0; digit_idx = 0; frame_start = 0.
  - Prescaler count, pending buffer, active buffer and pending_valid are all 0.
- Prescaler:
  - Counter width is clog2(REFRESH_DIV).
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit_idx increments; when digit_idx = NUM_DIGITS-1 it wraps to 0.
- Frame boundary: the cycle where the prescaler wraps and digit_idx goes NUM_DIGITS-1 -> 0.
  - If pending_valid = 1: active <= pending and pending_valid <= 0, in that same cycle.
  - frame_start = 1 during the first cycle of slot 0 (prescaler = 0, digit_idx = 0). After reset this occurs 1 cycle after reset deassertion.
- load:
  - Pending buffer <= {value, dp_mask} and pending_valid <= 1.
  - A load while pending_valid = 1 overwrites; last write wins.
  - load coinciding with the frame boundary: the active buffer takes the old pending contents, then the new load sets pending and pending_valid = 1. The new data is shown next frame.
- Outputs (registered, same cycle as the prescaler/index they reflect):
  - nibble = active nibble[digit_idx] for the whole slot, including the blank interval.
  - an: all ones while prescaler < BLANK_CYCLES. Otherwise bit digit_idx = ~digit_en[digit_idx] and all other bits = 1.
  - dp_n = 0 only when that anode is low and active dp_mask[digit_idx] = 1; otherwise 1.
- Never more than one anode low in any cycle.
- Reset mid-frame: immediate return to reset values. Any pending data is discarded.
- digit_en changes take effect from the next cycle; they are not double-buffered.
- Scan time per full frame is NUM_DIGITS*REFRESH_DIV cycles.

Optional Feature:
SSD_LEADING_ZERO_BLANK_EN
- Defined:
  - A digit i > 0 is suppressed (anode held high, dp_n = 1) when its active nibble and all active nibbles above it are 0.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - Suppression is computed from the active buffer only.
- Undefined: all enabled digits are displayed, including leading zeros. No extra logic is generated.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset then release:
   - frame_start pulses 1 cycle after release.
   - an = 4'b1111 in the slot's first cycle, then 4'b1110 for 3 cycles; nibble = 0.
   - digit_idx advances every 4 cycles and wraps 3 -> 0.
2. load value=16'h1234, dp_mask=4'b0100 mid-frame:
   - Display stays at 0 until the next frame_start.
   - Then nibble sequence is 4,3,2,1 with an lit low as 1110,1101,1011,0111.
   - dp_n = 0 only during digit 2's lit cycles.
3. Two loads in the same frame (16'hAAAA then 16'h5555):
   - Next frame shows 5 on all digits; A is never displayed.
4. load asserted exactly on the frame-boundary cycle while pending holds 16'h1111, with new value 16'h2222:
   - This frame shows 1111, next frame shows 2222.
5. digit_en=4'b0101 with value 16'h9999:
   - Digits 1 and 3 have their anode always high.
   - Never two anodes low in any cycle; all anodes high in every blank cycle.
6. With SSD_LEADING_ZERO_BLANK_EN defined:
   - value 16'h0040: only digits 1 and 0 light.
   - value 16'h0000: only digit 0 lights, nibble = 0.
   - Without the macro, value 16'h0040 lights all four digits.
